// File: rtl/cbd_sample_ctrl.sv
// Sequencer between a random-word source, a LANES-wide CBD sampler and a coefficient stream.
// Define CBD_CTRL_TIMEOUT_EN to enable the per-polynomial word budget (MAX_WORDS) and the error flag.
module cbd_sample_ctrl #(
    parameter int LANES      = 4,
    parameter int RAND_WIDTH = 128,
    parameter int CAND_BITS  = 4,
    parameter int BERN_WIDTH = 8,
    parameter int N_COEFFS   = 256,
    parameter int MAX_WORDS  = 1023
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_start,
    input  logic [BERN_WIDTH-1:0]      req_threshold,
    input  logic                       rnd_valid,
    output logic                       rnd_ready,
    input  logic [RAND_WIDTH-1:0]      rnd_data,
    output logic                       smp_start,
    output logic                       smp_valid,
    output logic [RAND_WIDTH-1:0]      smp_random,
    output logic [BERN_WIDTH-1:0]      smp_threshold,
    input  logic [LANES*CAND_BITS-1:0] smp_vals,
    input  logic [LANES-1:0]           smp_flags,
    input  logic                       smp_done,
    output logic                       coef_valid,
    input  logic                       coef_ready,
    output logic [CAND_BITS-1:0]       coef_data,
    output logic [7:0]                 coef_index,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [2:0]                 dbg_state
);
    // Handshakes (rnd_*, coef_*): a transfer happens on a rising edge where valid and ready
    // are both high; the payload stays stable from valid rising until that transfer.

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_DRAIN, S_FINISH
    } state_t;

    state_t                     state;
    logic [LANES-1:0]           mask_q;
    logic [LANES*CAND_BITS-1:0] vals_q;
    logic [8:0]                 count_q;
    logic [LW-1:0]              cur_lane;
    logic [LW-1:0]              nx_lane;
    logic [LANES-1:0]           mask_nx;
    logic [8:0]                 count_nx;

    function automatic logic [LW-1:0] low_lane(input logic [LANES-1:0] m);
        logic [LW-1:0] r;
        r = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (m[i]) r = LW'(i);
        end
        return r;
    endfunction

    function automatic logic [CAND_BITS-1:0] lane_val(input logic [LANES*CAND_BITS-1:0] v,
                                                      input logic [LW-1:0] l);
        return v[l*CAND_BITS +: CAND_BITS];
    endfunction

    always_comb begin
        cur_lane = low_lane(mask_q);
        mask_nx  = mask_q & ~(LANES'(1) << cur_lane);
        count_nx = count_q + 9'd1;
        nx_lane  = low_lane(mask_nx);
    end

`ifdef CBD_CTRL_TIMEOUT_EN
    logic [9:0] word_cnt;
    logic       error_q;
    logic       fetch_entry;
    logic [9:0] fetch_cnt;

    // Any transition that would land in FETCH is checked against the word budget.
    always_comb begin
        fetch_entry = (state == S_IDLE && req_start) ||
                      (state == S_WAIT && smp_done && smp_flags == '0) ||
                      (state == S_DRAIN && coef_ready && count_nx != 9'(N_COEFFS) && mask_nx == '0);
        fetch_cnt   = (state == S_IDLE) ? '0 : word_cnt;
    end
    assign error = error_q;
`else
    assign error = 1'b0;
`endif

    assign smp_valid = smp_start;
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            mask_q        <= '0;
            vals_q        <= '0;
            count_q       <= '0;
            rnd_ready     <= 1'b0;
            smp_start     <= 1'b0;
            smp_random    <= '0;
            smp_threshold <= '0;
            coef_valid    <= 1'b0;
            coef_data     <= '0;
            coef_index    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef CBD_CTRL_TIMEOUT_EN
            word_cnt      <= '0;
            error_q       <= 1'b0;
`endif
        end else begin
            done      <= 1'b0;
            smp_start <= 1'b0;
            case (state)
                S_IDLE: if (req_start) begin
                    smp_threshold <= req_threshold;
                    count_q       <= '0;
                    busy          <= 1'b1;
                    rnd_ready     <= 1'b1;
                    state         <= S_FETCH;
`ifdef CBD_CTRL_TIMEOUT_EN
                    word_cnt      <= '0;
                    error_q       <= 1'b0;
`endif
                end
                S_FETCH: if (rnd_valid) begin
                    smp_random <= rnd_data;
                    rnd_ready  <= 1'b0;
                    smp_start  <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
`ifdef CBD_CTRL_TIMEOUT_EN
                    word_cnt <= word_cnt + 10'd1;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: if (smp_done) begin
                    mask_q <= smp_flags;
                    vals_q <= smp_vals;
                    if (smp_flags == '0) begin
                        rnd_ready <= 1'b1;
                        state     <= S_FETCH;
                    end else begin
                        coef_valid <= 1'b1;
                        coef_data  <= lane_val(smp_vals, low_lane(smp_flags));
                        coef_index <= count_q[7:0];
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: if (coef_ready) begin
                    mask_q  <= mask_nx;
                    count_q <= count_nx;
                    // Reaching the coefficient target wins over any lanes still set.
                    if (count_nx == 9'(N_COEFFS)) begin
                        coef_valid <= 1'b0;
                        done       <= 1'b1;
                        state      <= S_FINISH;
                    end else if (mask_nx == '0) begin
                        coef_valid <= 1'b0;
                        rnd_ready  <= 1'b1;
                        state      <= S_FETCH;
                    end else begin
                        coef_data  <= lane_val(vals_q, nx_lane);
                        coef_index <= count_nx[7:0];
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
`ifdef CBD_CTRL_TIMEOUT_EN
            if (fetch_entry && fetch_cnt == 10'(MAX_WORDS)) begin
                rnd_ready <= 1'b0;
                error_q   <= 1'b1;
                done      <= 1'b1;
                state     <= S_FINISH;
            end
`endif
        end
    end
endmodule

// File: tb/tb_cbd_sample_ctrl.sv
// Randomized bench for cbd_sample_ctrl: expected coefficients come from a lane-order model
// of every sampled word, truncated at N coefficients (and at the word budget when enabled).
module tb_cbd_sample_ctrl;
    localparam int N = 8;
`ifdef CBD_CTRL_TIMEOUT_EN
    localparam int MAXW = 3;
`else
    localparam int MAXW = 1023;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req_start = 1'b0;
    logic [7:0]   req_threshold = '0;
    logic         rnd_valid = 1'b0;
    logic         rnd_ready;
    logic [127:0] rnd_data = '0;
    logic         smp_start, smp_valid;
    logic [127:0] smp_random;
    logic [7:0]   smp_threshold;
    logic [15:0]  smp_vals = '0;
    logic [3:0]   smp_flags = '0;
    logic         smp_done = 1'b0;
    logic         coef_valid;
    logic         coef_ready = 1'b0;
    logic [3:0]   coef_data;
    logic [7:0]   coef_index;
    logic         busy, done, error;
    logic [2:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [3:0]  exp_q[$];
    logic [3:0]  got_q[$];
    logic [3:0]  dir_flags_q[$];
    logic [15:0] dir_vals_q[$];
    int model_cnt;
    int words_issued;

    cbd_sample_ctrl #(.N_COEFFS(N), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .reset(reset), .req_start(req_start), .req_threshold(req_threshold),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_data(rnd_data),
        .smp_start(smp_start), .smp_valid(smp_valid), .smp_random(smp_random),
        .smp_threshold(smp_threshold), .smp_vals(smp_vals), .smp_flags(smp_flags),
        .smp_done(smp_done), .coef_valid(coef_valid), .coef_ready(coef_ready),
        .coef_data(coef_data), .coef_index(coef_index), .busy(busy), .done(done),
        .error(error), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // One polynomial with random source, sampler and sink agents, all acting on the falling edge.
    task automatic run_poly(input logic [7:0] thr, input int ready_pct, input int stall_cycles);
        logic [127:0] word_q[$];
        int pend, stall, exp_idx, last_acc, issue_due, coef_due, n_cyc;
        bit held_v, fin;
        logic [3:0] held_d, fl;
        logic [7:0] held_i;
        logic [15:0] vl;
        pend = 0; stall = stall_cycles; exp_idx = 0; last_acc = -10;
        issue_due = -1; coef_due = -1; n_cyc = 0; held_v = 0; fin = 0;
        held_d = '0; held_i = '0;
        exp_q.delete(); got_q.delete(); model_cnt = 0; words_issued = 0;
        @(negedge clk);
        req_threshold = thr; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || error !== 1'b0 || rnd_ready !== 1'b1)
            begin errors++; $display("FAIL start: busy=%b error=%b rnd_ready=%b required 1 0 1", busy, error, rnd_ready); end
        while (!fin && n_cyc < 2000) begin
            if (smp_start) begin
                checks++;
                if (smp_valid !== 1'b1 || word_q.size() == 0 || smp_random !== word_q[0] || smp_threshold !== thr) begin
                    errors++;
                    $display("FAIL issue: valid=%b random=%h threshold=%h required threshold=%h queued=%0d",
                             smp_valid, smp_random, smp_threshold, thr, word_q.size());
                end
                if (word_q.size() > 0) void'(word_q.pop_front());
                words_issued++;
                pend = $urandom_range(1, 3);
            end
            if (n_cyc == issue_due) begin
                checks++;
                if (smp_start !== 1'b1) begin errors++; $display("FAIL issue_latency: smp_start=%b required 1", smp_start); end
            end
            if (n_cyc == coef_due) begin
                checks++;
                if (coef_valid !== 1'b1) begin errors++; $display("FAIL coef_latency: coef_valid=%b required 1", coef_valid); end
            end
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL busy: got %b required 1", busy); end
            if (coef_valid) begin
                checks++;
                if (rnd_ready !== 1'b0) begin errors++; $display("FAIL drain_rnd_ready: got %b required 0", rnd_ready); end
                if (held_v) begin
                    checks++;
                    if (coef_data !== held_d || coef_index !== held_i) begin
                        errors++;
                        $display("FAIL stable: data=%h idx=%0d required data=%h idx=%0d", coef_data, coef_index, held_d, held_i);
                    end
                end
            end
            if (done) begin
                fin = 1;
                if (model_cnt == N) begin
                    checks++;
                    if (n_cyc != last_acc + 1) begin errors++; $display("FAIL done_timing: cycle %0d required %0d", n_cyc, last_acc + 1); end
                end
            end
            // Drive inputs for the next rising edge.
            req_start = ($urandom_range(0, 7) == 0);
            req_threshold = 8'($urandom);
            rnd_valid = ($urandom_range(0, 9) < 7);
            rnd_data = {$urandom, $urandom, $urandom, $urandom};
            if (rnd_valid && rnd_ready) begin
                word_q.push_back(rnd_data);
                issue_due = n_cyc + 1;
            end
            if (coef_valid) begin
                if (stall > 0) begin coef_ready = 1'b0; stall--; end
                else coef_ready = ($urandom_range(0, 99) < ready_pct);
                if (coef_ready) begin
                    checks++;
                    if (exp_q.size() == 0 || coef_data !== exp_q[0] || coef_index !== 8'(exp_idx)) begin
                        errors++;
                        $display("FAIL coef: data=%h idx=%0d required data=%h idx=%0d", coef_data, coef_index,
                                 (exp_q.size() > 0) ? exp_q[0] : 4'h0, exp_idx);
                    end
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    got_q.push_back(coef_data);
                    exp_idx++; last_acc = n_cyc; held_v = 0;
                end else begin
                    held_v = 1; held_d = coef_data; held_i = coef_index;
                end
            end else begin
                coef_ready = 1'($urandom_range(0, 1));
                held_v = 0;
            end
            smp_done = 1'b0;
            if (pend > 0 && !smp_start) begin
                pend--;
                if (pend == 0) begin
                    if (dir_flags_q.size() > 0) begin fl = dir_flags_q.pop_front(); vl = dir_vals_q.pop_front(); end
                    else begin fl = 4'($urandom); vl = 16'($urandom); end
                    smp_flags = fl; smp_vals = vl; smp_done = 1'b1;
                    for (int i = 0; i < 4; i++) begin
                        if (fl[i] && model_cnt < N) begin exp_q.push_back(vl[i*4 +: 4]); model_cnt++; end
                    end
                    if (fl != 4'h0) coef_due = n_cyc + 1;
                end
            end
            n_cyc++;
            @(negedge clk);
        end
        req_start = 1'b0; rnd_valid = 1'b0; smp_done = 1'b0; coef_ready = 1'b0;
        checks++;
        if (!fin) begin errors++; $display("FAIL done_timeout: no done within %0d cycles", n_cyc); end
        checks++;
        if (got_q.size() != model_cnt || exp_q.size() != 0)
            begin errors++; $display("FAIL coef_count: got %0d required %0d", got_q.size(), model_cnt); end
        checks++;
`ifdef CBD_CTRL_TIMEOUT_EN
        if (error !== (model_cnt < N) || (model_cnt < N && words_issued != MAXW))
            begin errors++; $display("FAIL error_flag: error=%b words=%0d required error=%b", error, words_issued, model_cnt < N); end
`else
        if (error !== 1'b0) begin errors++; $display("FAIL error_flag: got %b required 0", error); end
`endif
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || coef_valid !== 1'b0 || smp_threshold !== thr)
            begin errors++; $display("FAIL idle_after: done=%b busy=%b coef_valid=%b thr=%h required 0 0 0 %h", done, busy, coef_valid, smp_threshold, thr); end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({busy, done, error, rnd_ready, smp_start, smp_valid, coef_valid, coef_data, coef_index} !== '0 ||
            smp_random !== '0 || smp_threshold !== '0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b error=%b rnd_ready=%b start=%b cv=%b cd=%h ci=%h rnd=%h thr=%h required all 0",
                     tag, busy, done, error, rnd_ready, smp_start, coef_valid, coef_data, coef_index, smp_random, smp_threshold);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("reset_held");
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("reset_released");
    endtask

    task automatic test_full_flags();
        dir_flags_q = '{4'hF, 4'hF};
        dir_vals_q  = '{16'h1234, 16'h9ABC};
        run_poly(8'h21, 100, 0);
        checks++;
        if (words_issued != 2 || got_q.size() != 8)
            begin errors++; $display("FAIL full_flags: words=%0d coefs=%0d required 2 8", words_issued, got_q.size()); end
    endtask

    task automatic test_lane_order();
        dir_flags_q = '{4'b1010};
        dir_vals_q  = '{16'h5A3C};
        run_poly(8'h3C, 100, 0);
        checks++;
        if (got_q.size() < 2 || got_q[0] !== 4'h3 || got_q[1] !== 4'h5)
            begin errors++; $display("FAIL lane_order: first=%h second=%h required 3 5",
                                     (got_q.size() > 0) ? got_q[0] : 4'h0, (got_q.size() > 1) ? got_q[1] : 4'h0); end
    endtask

    task automatic test_truncate();
        dir_flags_q = '{4'b0111, 4'hF, 4'hF};
        dir_vals_q  = '{16'h0321, 16'h7654, 16'hDCBE};
        run_poly(8'h55, 70, 0);
        checks++;
        if (words_issued != 3 || got_q.size() != 8 || got_q[got_q.size()-1] !== 4'hE)
            begin errors++; $display("FAIL truncate: words=%0d coefs=%0d required 3 8 last E", words_issued, got_q.size()); end
    endtask

    task automatic test_stall();
        dir_flags_q = '{4'hF};
        dir_vals_q  = '{16'hFEDC};
        run_poly(8'h90, 100, 5);
    endtask

    task automatic test_random();
        for (int p = 0; p < 6; p++) run_poly(8'($urandom), 50, $urandom_range(0, 3));
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        dir_flags_q.delete(); dir_vals_q.delete();
        @(negedge clk);
        req_threshold = 8'h77; req_start = 1'b1;
        @(negedge clk);
        req_start = 1'b0; rnd_valid = 1'b1; rnd_data = {$urandom, $urandom, $urandom, $urandom};
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            rnd_valid = 1'b0;
            seen = smp_start;
        end
        checks++;
        if (!seen) begin errors++; $display("FAIL rst_wait_issue: smp_start never seen, required 1"); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; smp_flags = 4'hF; smp_vals = 16'h4321; smp_done = 1'b1;
        @(negedge clk);
        smp_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_all_zero("reset_in_wait");
            @(negedge clk);
        end
    endtask

`ifdef CBD_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        dir_flags_q = '{4'h0, 4'h0, 4'h0};
        dir_vals_q  = '{16'h1111, 16'h2222, 16'h3333};
        run_poly(8'hA5, 100, 0);
        checks++;
        if (words_issued != 3 || got_q.size() != 0 || error !== 1'b1)
            begin errors++; $display("FAIL timeout: words=%0d coefs=%0d error=%b required 3 0 1", words_issued, got_q.size(), error); end
    endtask
`endif

    initial begin
        test_reset();
        test_full_flags();
        test_lane_order();
        test_truncate();
        test_stall();
        test_random();
        test_reset_in_wait();
`ifdef CBD_CTRL_TIMEOUT_EN
        test_timeout();
        test_full_flags();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cbd_sample_ctrl.md
CBD_SAMPLE_CTRL -- requirements
Module: cbd_sample_ctrl

Interface
REQ-001 Parameter LANES, default 4, sampler lanes per random word.
REQ-002 Parameter RAND_WIDTH, default 128, random word width.
REQ-003 Parameter CAND_BITS, default 4, coefficient width.
REQ-004 Parameter BERN_WIDTH, default 8, threshold width.
REQ-005 Parameter N_COEFFS, default 256, coefficients per polynomial (range 1..256).
REQ-006 Parameter MAX_WORDS, default 1023, word budget per polynomial (10-bit counter).
REQ-007 clk  in  1  single clock, all logic on rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 req_start  in  1  one-cycle pulse that begins a polynomial.
REQ-010 req_threshold  in  BERN_WIDTH  threshold, latched on accepted req_start.
REQ-011 rnd_valid / rnd_ready  in / out  1 / 1  random-source handshake.
REQ-012 rnd_data  in  RAND_WIDTH  random word.
REQ-013 smp_start, smp_valid  out  1  sampler strobes.
REQ-014 smp_random  out  RAND_WIDTH; smp_threshold  out  BERN_WIDTH  sampler operands.
REQ-015 smp_vals  in  LANES*CAND_BITS; smp_flags  in  LANES; smp_done  in  1  sampler results.
REQ-016 coef_valid / coef_ready  out / in  1 / 1  coefficient stream handshake.
REQ-017 coef_data  out  CAND_BITS; coef_index  out  8  coefficient value and position.
REQ-018 busy  out  1; done  out  1 (pulse); error  out  1 (sticky until next req_start).

Function
REQ-019 FSM states: IDLE, FETCH, ISSUE, WAIT, DRAIN, FINISH.
- IDLE: req_start -> FETCH, latch threshold, clear count, word counter, error.
- req_start outside IDLE: ignored.
REQ-020 FETCH: rnd_ready=1; on rnd_valid&rnd_ready, latch rnd_data -> ISSUE.
REQ-021 ISSUE: smp_start=smp_valid=1 for exactly one cycle, smp_random=latched word, word counter +1 -> WAIT.
REQ-022 WAIT: on smp_done, register smp_vals/smp_flags into mask. flags==0 -> FETCH; otherwise -> DRAIN.
REQ-023 DRAIN: coef_valid=1, coef_data = lowest-numbered set lane of mask, coef_index = count.
- On coef_ready: clear that bit and count+1.
- count reaches N_COEFFS -> FINISH; remaining lanes discarded.
- Mask empty -> FETCH.
REQ-024 coef_data and coef_index SHALL remain stable while coef_valid=1 and coef_ready=0.
REQ-025 FINISH: done=1 for one cycle -> IDLE.
REQ-026 busy=1 in every state except IDLE; smp_threshold = latched threshold at all times.
REQ-027 smp_done outside WAIT SHALL be ignored.
REQ-028 Minimum per-word latency: FETCH accept -> ISSUE next cycle -> first coef_valid one cycle after smp_done.

Reset
REQ-029 reset SHALL force IDLE and clear the mask, count, word counter and latched operands.
- All outputs 0: busy, done, error, rnd_ready, smp_start, smp_valid, coef_valid, coef_data, coef_index, smp_random, smp_threshold.
REQ-030 reset mid-operation SHALL abandon the polynomial with no done pulse; a stale smp_done after reset SHALL be ignored.

Configuration
REQ-031 Macro CBD_CTRL_TIMEOUT_EN.
- Defined: entering FETCH with word counter == MAX_WORDS SHALL set error and go to FINISH (done still pulses).
- Undefined: no budget check, error tied 0, word counter absent.

Verification
REQ-032 N_COEFFS=8, flags 4'hF every word, coef_ready=1 -> 2 words, indices 0..7, done one cycle after index 7.
REQ-033 flags 4'b1010, smp_vals 16'h5A3C -> coef_data 4'h3 (idx 0), then 4'h5 (idx 1), then FETCH.
REQ-034 N_COEFFS=6, flags 4'hF twice -> exactly 6 coefficients, lanes 2-3 of word 2 dropped, done pulse.
REQ-035 coef_ready held 0 for 5 cycles in DRAIN -> coef_data/coef_index constant; rnd_ready stays 0.
REQ-036 reset asserted in WAIT, then smp_done -> no coef_valid, no done; IDLE, all outputs 0.
REQ-037 With CBD_CTRL_TIMEOUT_EN, MAX_WORDS=3, flags 0 always -> 3 ISSUE pulses, error=1, done pulse, 0 coefficients.
